// File: rtl/sig_capture.sv
// Sample capture buffer with arm/trigger/done control and a registered readback port.
// Optional circular pre-trigger recording is enabled by defining SIG_CAPTURE_PRETRIG_EN.
module sig_capture #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     arm,
    input  logic                     trig,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   wr_count,
    output logic [ADDRESS_WIDTH-1:0] start_addr
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

`ifdef SIG_CAPTURE_PRETRIG_EN
    localparam logic [ADDRESS_WIDTH:0] CAP_LEN = (ADDRESS_WIDTH+1)'(DEPTH / 2);
`else
    localparam logic [ADDRESS_WIDTH:0] CAP_LEN = (ADDRESS_WIDTH+1)'(DEPTH);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0]   wr_count_q, wr_count_d;
    logic [DATA_WIDTH-1:0]    dout_q;
    logic                     wr_en;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

`ifdef SIG_CAPTURE_PRETRIG_EN
    logic [ADDRESS_WIDTH-1:0] start_addr_q, start_addr_d;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        wr_en      = 1'b0;
`ifdef SIG_CAPTURE_PRETRIG_EN
        start_addr_d = start_addr_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d    = ARMED;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                end
            end

            ARMED: begin
`ifdef SIG_CAPTURE_PRETRIG_EN
                // Pre-trigger samples overwrite the ring continuously until the trigger.
                if (en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
`else
                if (trig && en) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
`endif
                if (trig) begin
                    state_d    = CAPTURE;
                    wr_count_d = en ? (ADDRESS_WIDTH+1)'(1) : '0;
                end
            end

            CAPTURE: begin
                if (en) begin
                    wr_en      = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    wr_count_d = wr_count_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The write that completes the capture length moves straight to DONE.
        if (wr_en && (state_d == CAPTURE) && (wr_count_d == CAP_LEN)) begin
            state_d = DONE;
`ifdef SIG_CAPTURE_PRETRIG_EN
            start_addr_d = wr_ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            dout_q     <= '0;
`ifdef SIG_CAPTURE_PRETRIG_EN
            start_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            dout_q     <= mem[rd_addr];
`ifdef SIG_CAPTURE_PRETRIG_EN
            start_addr_q <= start_addr_d;
`endif
        end
    end

    // RAM contents survive reset; a same-address read in the write cycle sees old data.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout     = dout_q;
    assign busy     = (state_q == ARMED) || (state_q == CAPTURE);
    assign done     = (state_q == DONE);
    assign wr_count = wr_count_q;

`ifdef SIG_CAPTURE_PRETRIG_EN
    assign start_addr = start_addr_q;
`else
    assign start_addr = '0;
`endif

endmodule

// File: tb/tb_sig_capture.sv
// Self-checking bench for sig_capture (ADDRESS_WIDTH=4, DATA_WIDTH=8) using a readback scoreboard.
// Define SIG_CAPTURE_PRETRIG_EN to exercise the pre-trigger build.
module tb_sig_capture;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] din;
    logic          arm;
    logic          trig;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [AW-1:0] start_addr;

    int total;
    int bad;

    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] sb_q [$];

    sig_capture #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .din(din),
        .arm(arm),
        .trig(trig),
        .rd_addr(rd_addr),
        .dout(dout),
        .busy(busy),
        .done(done),
        .wr_count(wr_count),
        .start_addr(start_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [AW-1:0] addr);
        rd_addr = addr;
        sb_q.push_back(exp_mem[addr]);
    endtask

    task automatic check_status(input string name, input logic exp_busy,
                                input logic exp_done, input logic [AW:0] exp_count);
        total++;
        if ({busy, done, wr_count} !== {exp_busy, exp_done, exp_count}) begin
            bad++;
            $display("[TB] FAIL %s: busy=%b done=%b wr_count=%0d, expected busy=%b done=%b wr_count=%0d",
                     name, busy, done, wr_count, exp_busy, exp_done, exp_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; din = '0; arm = 1'b0; trig = 1'b0; rd_addr = '0;
        tick();
        tick();
        total++;
        if (dout !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_dout: got %h expected 00", dout);
        end
        check_status("reset_status", 1'b0, 1'b0, '0);
        total++;
        if (start_addr !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_start_addr: got %0d expected 0", start_addr);
        end
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = AW'(k);
            tick();
        end
        check_status("idle_after_sweep", 1'b0, 1'b0, '0);
    endtask

`ifndef SIG_CAPTURE_PRETRIG_EN
    // Full capture of 16 consecutive samples starting at base value.
    task automatic run_capture(input logic [DW-1:0] base);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1; en = 1'b1; din = base;
        tick();
        exp_mem[0] = base;
        trig = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            din = base + DW'(k);
            tick();
            exp_mem[k] = base + DW'(k);
        end
        en = 1'b0;
    endtask

    task automatic test_capture();
        logic [DW-1:0] exp;
        logic [DW-1:0] prev;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_status("armed", 1'b1, 1'b0, '0);
        en = 1'b1;
        din = 8'hEE;
        tick();
        check_status("armed_en_no_trig", 1'b1, 1'b0, '0);
        trig = 1'b1; din = 8'h10;
        tick();
        exp_mem[0] = 8'h10;
        trig = 1'b0;
        check_status("first_write", 1'b1, 1'b0, 5'd1);
        for (int k = 1; k < DEPTH; k++) begin
            din = 8'h10 + DW'(k);
            if (k == DEPTH - 1) check_status("before_last", 1'b1, 1'b0, 5'd15);
            tick();
            exp_mem[k] = 8'h10 + DW'(k);
        end
        en = 1'b0;
        check_status("capture_done", 1'b0, 1'b1, 5'd16);
        prev = dout;
        for (int k = 0; k < DEPTH; k++) begin
            issue_read(AW'(k));
            #1;
            total++;
            if (dout !== prev) begin
                bad++;
                $display("[TB] FAIL read_latency addr=%0d: got %h expected %h", k, dout, prev);
            end
            tick();
            exp = sb_q.pop_front();
            prev = exp;
            total++;
            if (dout !== exp) begin
                bad++;
                $display("[TB] FAIL capture_read addr=%0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_gap();
        logic [DW-1:0] exp;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1; en = 1'b1; din = 8'h40;
        tick();
        exp_mem[0] = 8'h40;
        trig = 1'b0;
        for (int k = 1; k < 8; k++) begin
            din = 8'h40 + DW'(k);
            tick();
            exp_mem[k] = 8'h40 + DW'(k);
        end
        en = 1'b0;
        din = 8'hFF;
        for (int g = 0; g < 5; g++) begin
            tick();
            check_status("gap_frozen", 1'b1, 1'b0, 5'd8);
        end
        en = 1'b1;
        for (int k = 8; k < DEPTH; k++) begin
            din = 8'h40 + DW'(k);
            tick();
            exp_mem[k] = 8'h40 + DW'(k);
        end
        en = 1'b0;
        check_status("gap_done", 1'b0, 1'b1, 5'd16);
        for (int k = 0; k < DEPTH; k++) begin
            issue_read(AW'(k));
            tick();
            exp = sb_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("[TB] FAIL gap_read addr=%0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] exp;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1; en = 1'b1; din = 8'h60;
        tick();
        trig = 1'b0;
        for (int k = 1; k < 7; k++) begin
            din = 8'h60 + DW'(k);
            tick();
        end
        check_status("mid_seven", 1'b1, 1'b0, 5'd7);
        en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_status("mid_reset", 1'b0, 1'b0, '0);
        run_capture(8'h80);
        check_status("after_reset_done", 1'b0, 1'b1, 5'd16);
        for (int k = 0; k < DEPTH; k++) begin
            issue_read(AW'(k));
            tick();
            exp = sb_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("[TB] FAIL overwrite_read addr=%0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_ignore();
        logic [DW-1:0] exp;
        en = 1'b1; din = 8'hFF;
        tick();
        en = 1'b0; trig = 1'b1;
        tick();
        trig = 1'b0;
        check_status("done_ignore", 1'b0, 1'b1, 5'd16);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_status("done_rearm", 1'b1, 1'b0, '0);
        en = 1'b1; din = 8'hFF;
        tick();
        en = 1'b0;
        check_status("armed_no_trig", 1'b1, 1'b0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b1; trig = 1'b1; din = 8'hFF;
        tick();
        en = 1'b0; trig = 1'b0;
        tick();
        check_status("idle_ignore", 1'b0, 1'b0, '0);
        for (int k = 0; k < DEPTH; k++) begin
            issue_read(AW'(k));
            tick();
            exp = sb_q.pop_front();
            total++;
            if (dout !== exp) begin
                bad++;
                $display("[TB] FAIL ram_unchanged addr=%0d: got %h expected %h", k, dout, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        rd_addr = '0;
        trig = 1'b1; en = 1'b1; din = 8'hA0;
        tick();
        trig = 1'b0; en = 1'b0;
        total++;
        if (dout !== exp_mem[0]) begin
            bad++;
            $display("[TB] FAIL rdw_old_data: got %h expected %h", dout, exp_mem[0]);
        end
        exp_mem[0] = 8'hA0;
        tick();
        total++;
        if (dout !== exp_mem[0]) begin
            bad++;
            $display("[TB] FAIL rdw_new_data: got %h expected %h", dout, exp_mem[0]);
        end
        check_status("rdw_status", 1'b1, 1'b0, 5'd1);
    endtask
`else
    task automatic test_pretrig();
        logic [DW-1:0] exp;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = DW'(k);
            tick();
            exp_mem[k % DEPTH] = DW'(k);
        end
        check_status("pretrig_armed", 1'b1, 1'b0, '0);
        trig = 1'b1; din = 8'd20;
        tick();
        exp_mem[4] = 8'd20;
        trig = 1'b0;
        check_status("pretrig_trigger", 1'b1, 1'b0, 5'd1);
        for (int k = 21; k < 28; k++) begin
            din = DW'(k);
            tick();
            exp_mem[k % DEPTH] = DW'(k);
        end
        en = 1'b0;
        check_status("pretrig_done", 1'b0, 1'b1, 5'd8);
        total++;
        if (start_addr !== 4'd12) begin
            bad++;
            $display("[TB] FAIL pretrig_start_addr: got %0d expected 12", start_addr);
        end
        for (int k = 0; k < DEPTH; k++) begin
            issue_read(AW'((12 + k) % DEPTH));
            tick();
            exp = sb_q.pop_front();
            total++;
            if (dout !== exp || exp !== DW'(12 + k)) begin
                bad++;
                $display("[TB] FAIL pretrig_read idx=%0d: got %h expected %h", k, dout, DW'(12 + k));
            end
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
        test_reset();
`ifndef SIG_CAPTURE_PRETRIG_EN
        test_capture();
        test_gap();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
`else
        test_pretrig();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
